// File: rtl/tlb_pkg.sv
// Shared TLB replacement definitions: policy codes, LFSR constants, FSM states
// and tree-PLRU helpers sized for up to 64 entries so other TLB levels can reuse them.
package tlb_pkg;

  localparam int REPL_PLRU = 0;
  localparam int REPL_RR   = 1;
  localparam int REPL_LFSR = 2;

  localparam int PLRU_MAX_LVL = 6;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } repl_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Tree bit n lives at tree[n]; bit 0 is unused.
  function automatic logic [5:0] plru_victim(input logic [63:0] tree, input int idx_w);
    int node;
    logic [5:0] idx;
    node = 1;
    idx  = '0;
    for (int lvl = 0; lvl < PLRU_MAX_LVL; lvl++) begin
      if (lvl < idx_w) begin
        idx  = {idx[4:0], tree[node]};
        node = 2 * node + int'(tree[node]);
      end
    end
    return idx;
  endfunction

  function automatic logic [63:0] plru_update(input logic [63:0] tree, input logic [5:0] idx,
                                              input int idx_w);
    logic [63:0] t;
    logic b;
    int node;
    t    = tree;
    node = 1;
    for (int lvl = 0; lvl < PLRU_MAX_LVL; lvl++) begin
      if (lvl < idx_w) begin
        b       = idx[idx_w-1-lvl];
        t[node] = ~b;
        node    = 2 * node + int'(b);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/tlb_plru_tree.sv
// Tree-PLRU state: fill update is applied before the touch so the touch wins
// at shared nodes; victim reflects the registered tree only.
module tlb_plru_tree
  import tlb_pkg::*;
#(
  parameter int  ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fill_vld,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic             touch_vld,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] victim
);

  logic [ENTRIES-1:1] tree_q, tree_d;
  logic [63:0] cur, after_fill, after_touch;

  assign cur    = 64'(tree_q) << 1;
  assign victim = IDX_W'(plru_victim(cur, IDX_W));

  always_comb begin
    after_fill  = fill_vld ? plru_update(cur, 6'(fill_idx), IDX_W) : cur;
    after_touch = touch_vld ? plru_update(after_fill, 6'(touch_idx), IDX_W) : after_fill;
    tree_d      = (ENTRIES-1)'(after_touch >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tree_q <= '0;
    else if (clear) tree_q <= '0;
    else            tree_q <= tree_d;
  end

endmodule

// File: rtl/tlb_repl_ctrl.sv
// TLB replacement controller: owns policy state and hands out victims over a
// request/grant/fill handshake.
//   state | meaning
//   IDLE  | ready for a request; victim chosen and latched on accept
//   GRANT | one-cycle grant pulse, repl_idx valid
//   WAIT  | victim outstanding until fill_done
module tlb_repl_ctrl
  import tlb_pkg::*;
#(
  parameter int  ENTRIES = 8,
  parameter int  MODE    = 0,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] valid,
  input  logic               flush,
  input  logic               touch_vld,
  input  logic [IDX_W-1:0]   touch_idx,
  input  logic               repl_req,
  output logic               repl_rdy,
  output logic               repl_gnt,
  output logic [IDX_W-1:0]   repl_idx,
  input  logic               fill_done,
  output logic               busy
);

  repl_state_e state_q, state_d;
  logic accept, fill_acc, touch_acc, has_inv;
  logic [IDX_W-1:0] inv_idx, policy_idx, victim_idx;

  assign repl_rdy  = (state_q == ST_IDLE);
  assign repl_gnt  = (state_q == ST_GRANT);
  assign busy      = (state_q == ST_GRANT) || (state_q == ST_WAIT);
  assign accept    = repl_req && repl_rdy && !flush;
  assign fill_acc  = fill_done && (state_q == ST_WAIT) && !flush;
  assign touch_acc = touch_vld && !flush;

  always_comb begin
    has_inv = 1'b0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_inv = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end

  assign victim_idx = has_inv ? inv_idx : policy_idx;

  if (MODE == REPL_PLRU) begin : g_plru
    tlb_plru_tree #(.ENTRIES(ENTRIES)) u_tree (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .fill_vld (fill_acc),
      .fill_idx (repl_idx),
      .touch_vld(touch_acc),
      .touch_idx(touch_idx),
      .victim   (policy_idx)
    );
  end else if (MODE == REPL_RR) begin : g_rr
    logic [IDX_W-1:0] ptr_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ptr_q <= '0;
      else if (flush)    ptr_q <= '0;
      else if (fill_acc) ptr_q <= ptr_q + IDX_W'(1);
    end
    assign policy_idx = ptr_q;
  end else begin : g_lfsr
    // Free-running; flush deliberately leaves the sequence alone.
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_next(lfsr_q);
    end
    assign policy_idx = lfsr_q[IDX_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept) state_d = ST_GRANT;
        ST_GRANT: state_d = ST_WAIT;
        ST_WAIT:  if (fill_done) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      repl_idx <= '0;
    end else begin
      state_q <= state_d;
      if (accept) repl_idx <= victim_idx;
    end
  end

endmodule

// File: doc/tlb_repl_ctrl.md
# tlb_repl_ctrl

Parametrised, stateful replacement controller for the TLB. It is the successor to the purely combinational 8-entry victim picker. The block owns the replacement state: a tree-PLRU, a round-robin pointer or an LFSR. It updates that state on hits and fills, and hands out victims through a request/grant/fill handshake. It sits beside the TLB entry array: the lookup path drives touches, and the refill engine drives requests and fills.

## Interface
Parameters:
- ENTRIES, 8, number of TLB entries; power of two, 2..64
- MODE, 0, replacement policy: 0 = tree-PLRU, 1 = round-robin, 2 = LFSR pseudo-random
- IDX_W, $clog2(ENTRIES), entry index width (derived, not overridable)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- valid  in  ENTRIES  per-entry valid bits from the entry array
- flush  in  1  synchronous clear of replacement state and handshake
- touch_vld  in  1  lookup hit this cycle
- touch_idx  in  IDX_W  hit entry index
- repl_req  in  1  refill engine requests a victim
- repl_rdy  out  1  high in IDLE; request accepted when repl_req && repl_rdy
- repl_gnt  out  1  one-cycle pulse; repl_idx is valid this cycle
- repl_idx  out  IDX_W  granted victim; held until the next grant
- fill_done  in  1  victim entry has been written
- busy  out  1  a granted victim is outstanding (GRANT or WAIT)

## Operation
- **FSM states.** IDLE, GRANT and WAIT.
  - IDLE -> GRANT on an accepted request; the victim is latched into repl_idx.
  - GRANT -> WAIT unconditionally.
  - WAIT -> IDLE on fill_done.
  - flush forces IDLE from any state.
- **Victim selection.** Evaluated in the accept cycle from the current valid bits and policy state.
  - Invalid-first: if any valid bit is 0, the victim is the lowest-index invalid entry, in every mode.
  - Otherwise the victim comes from the policy.
- **Tree-PLRU (MODE 0).**
  - State is a tree of ENTRIES-1 bits, tree[ENTRIES-1:1]; node n has children 2n and 2n+1.
  - Victim walk: start at node 1, go to child 2n+tree[n], repeat for IDX_W levels. The path bits, MSB first, form the index.
  - Update for index i: every node on i's path is set to the inverse of i's bit at that level, so it points away from i.
- **Round-robin (MODE 1).**
  - An IDX_W-bit pointer gives the victim.
  - The pointer increments, wrapping from ENTRIES-1 to 0, on each fill_done accepted in WAIT.
  - Touches are ignored.
- **LFSR (MODE 2).**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. It steps every cycle.
  - Victim = lfsr[IDX_W-1:0]. Touches are ignored.
- **Fill.** fill_done in WAIT updates the policy as a touch of repl_idx. fill_done outside WAIT is ignored.
- **Touch and fill in the same cycle.** The fill update is applied first, then the touch. The touch wins at shared tree nodes.
- **Touch in GRANT/WAIT.** Allowed and applied normally; the outstanding repl_idx is unaffected.
- **flush.** Highest priority. Clears the tree to 0, the pointer to 0 and the FSM to IDLE, and suppresses any same-cycle request, touch or fill. The LFSR is not reseeded.

## Timing
- **Reset values.** repl_gnt=0, repl_idx=0, busy=0, repl_rdy=1, tree=0, pointer=0, lfsr=16'hACE1.
- **Grant latency.** Request accepted in cycle N -> repl_gnt=1 with repl_idx in cycle N+1. busy is high from N+1 until fill_done is sampled.
- **Back-to-back.** repl_rdy returns in the cycle after fill_done, so the minimum request-to-request spacing is 3 cycles.
- **Visibility of updates.** Touch or fill updates in cycle N affect a victim selected in cycle N+1 or later.
- **Async reset.** rst_n low in any state sets all outputs to reset values immediately, without waiting for clk.

## Structure
- **Shared package tlb_pkg:**
  - replacement-mode constants REPL_PLRU=0, REPL_RR=1, REPL_LFSR=2
  - LFSR seed and taps
  - FSM state enum
  - a function for tree-PLRU victim walk and path update, reusable by the L2 TLB
- **Sub-module tlb_plru_tree:** holds tree state and exposes the victim index and the update port. It is instantiated only when MODE==0.

## Test plan
- **Reset, PLRU walk.** ENTRIES=8, MODE 0, valid=8'hFF after reset, request -> repl_gnt next cycle with repl_idx=0. Then fill_done, touch 0, request -> repl_idx=4.
- **Invalid-first.** valid=8'hF5 -> repl_idx=1. valid=8'h7F -> repl_idx=7, regardless of tree state.
- **Touch/fill ordering.** From reset, touch 0, then fill of victim 4 -> next victim 2. Same-cycle touch 2 with fill_done of 4 -> tree nodes on 2's path point away from 2.
- **Round-robin.** MODE 1, all valid, four request/fill pairs -> repl_idx 0,1,2,3. Touches interleaved have no effect. Wrap check: after 8 fills, repl_idx=0.
- **Flush.** flush asserted in WAIT -> busy=0 and repl_rdy=1 the next cycle. A later fill_done is ignored and the tree reads 0.
- **Async reset.** rst_n low for half a cycle during GRANT -> repl_gnt and busy drop immediately. After release, a request returns repl_idx=0.
